// File: rtl/axi_common_types_pkg.sv
// Shared AXI4 encodings, engine state types and address-decode helpers
// used by the memory responder and its burst address generator.
package axi_common_types_pkg;

    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;
    localparam int CHK_W   = 64;

    typedef enum logic [RESP_W-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [BURST_W-1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    // Widened to CHK_W so base+span never overflows the comparison.
    function automatic logic addr_in_range(input logic [CHK_W-1:0] addr,
                                           input logic [CHK_W-1:0] base,
                                           input logic [CHK_W-1:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

    function automatic logic xfer_supported(input logic [BURST_W-1:0] burst,
                                            input logic [SIZE_W-1:0]  size,
                                            input int                 strb_w);
        return ((burst == BURST_FIXED) || (burst == BURST_INCR)) &&
               ((32'd1 << size) <= 32'(strb_w));
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR bursts plus a decode of whether that
// next address still falls inside this slave's window.
module axi_burst_addr_gen
    import axi_common_types_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [CHK_W-1:0]  SPAN      = 64'd4096
) (
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [SIZE_W-1:0]  i_size,
    input  logic [BURST_W-1:0] i_burst,
    output logic [ADDR_W-1:0]  o_next_addr,
    output logic               o_next_in_range
);

    logic [ADDR_W-1:0] w_step;

    assign w_step          = {{(ADDR_W-1){1'b0}}, 1'b1} << i_size;
    assign o_next_addr     = (i_burst == BURST_INCR) ? i_addr + w_step : i_addr;
    assign o_next_in_range = addr_in_range(CHK_W'(o_next_addr), CHK_W'(BASE_ADDR), SPAN);

endmodule

// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave endpoint backed by a local word memory, with independent
// write and read engines and a configurable read latency.
module axi_slave_mem_responder
    import axi_common_types_pkg::*;
#(
    parameter int                ID_W       = 4,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                LEN_W      = 8,
    parameter int                USER_W     = 1,
    parameter int                MEM_WORDS  = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                RD_LATENCY = 2
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     S_AWID,
    input  logic [ADDR_W-1:0]   S_AWADDR,
    input  logic [LEN_W-1:0]    S_AWLEN,
    input  logic [2:0]          S_AWSIZE,
    input  logic [1:0]          S_AWBURST,
    input  logic                S_AWLOCK,
    input  logic [3:0]          S_AWCACHE,
    input  logic [2:0]          S_AWPROT,
    input  logic [3:0]          S_AWQOS,
    input  logic [3:0]          S_AWREGION,
    input  logic [USER_W-1:0]   S_AWUSER,
    input  logic                S_AWVALID,
    output logic                S_AWREADY,
    input  logic [DATA_W-1:0]   S_WDATA,
    input  logic [DATA_W/8-1:0] S_WSTRB,
    input  logic                S_WLAST,
    input  logic [USER_W-1:0]   S_WUSER,
    input  logic                S_WVALID,
    output logic                S_WREADY,
    output logic [ID_W-1:0]     S_BID,
    output logic [1:0]          S_BRESP,
    output logic [USER_W-1:0]   S_BUSER,
    output logic                S_BVALID,
    input  logic                S_BREADY,
    input  logic [ID_W-1:0]     S_ARID,
    input  logic [ADDR_W-1:0]   S_ARADDR,
    input  logic [LEN_W-1:0]    S_ARLEN,
    input  logic [2:0]          S_ARSIZE,
    input  logic [1:0]          S_ARBURST,
    input  logic                S_ARLOCK,
    input  logic [3:0]          S_ARCACHE,
    input  logic [2:0]          S_ARPROT,
    input  logic [3:0]          S_ARQOS,
    input  logic [3:0]          S_ARREGION,
    input  logic [USER_W-1:0]   S_ARUSER,
    input  logic                S_ARVALID,
    output logic                S_ARREADY,
    output logic [ID_W-1:0]     S_RID,
    output logic [DATA_W-1:0]   S_RDATA,
    output logic [1:0]          S_RRESP,
    output logic                S_RLAST,
    output logic [USER_W-1:0]   S_RUSER,
    output logic                S_RVALID,
    input  logic                S_RREADY
);

    localparam int               STRB_W   = DATA_W / 8;
    localparam int               IDX_W    = $clog2(MEM_WORDS);
    localparam int               OFF_W    = $clog2(STRB_W);
    localparam logic [CHK_W-1:0] SPAN     = CHK_W'(MEM_WORDS) * CHK_W'(STRB_W);
    localparam logic [3:0]       LAT_LOAD = 4'(RD_LATENCY - 1);

    function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> OFF_W);
    endfunction

    function automatic logic req_err(input logic [ADDR_W-1:0] addr,
                                     input logic [1:0] burst, input logic [2:0] size);
        return !addr_in_range(CHK_W'(addr), CHK_W'(BASE_ADDR), SPAN) ||
               !xfer_supported(burst, size, STRB_W);
    endfunction

    logic [DATA_W-1:0] r_mem [MEM_WORDS];
    logic              r_en;

    w_state_e          r_wstate;
    logic [ID_W-1:0]   r_wid;
    logic [ADDR_W-1:0] r_waddr;
    logic [LEN_W-1:0]  r_wlen;
    logic [2:0]        r_wsize;
    logic [1:0]        r_wburst;
    logic              r_werr, r_wlen_err;
    logic [LEN_W:0]    r_wbeat;
    logic [ADDR_W-1:0] w_wnext_addr;
    logic              w_wnext_in_range, w_aw_hs, w_w_hs, w_mem_we;

    r_state_e          r_rstate;
    logic [ID_W-1:0]   r_rid;
    logic [ADDR_W-1:0] r_raddr;
    logic [LEN_W-1:0]  r_rlen;
    logic [2:0]        r_rsize;
    logic [1:0]        r_rburst;
    logic              r_rerr, r_rlast;
    logic [LEN_W:0]    r_rbeat;
    logic [3:0]        r_rcnt;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic [ADDR_W-1:0] w_rnext_addr, w_r_ld_addr;
    logic              w_rnext_in_range, w_ar_hs, w_r_hs;
    logic              w_r_load, w_r_ld_err, w_r_ld_last;
    logic              w_unused;

    assign w_unused = ^{S_AWLOCK, S_AWCACHE, S_AWPROT, S_AWQOS, S_AWREGION, S_AWUSER, S_WUSER,
                        S_ARLOCK, S_ARCACHE, S_ARPROT, S_ARQOS, S_ARREGION, S_ARUSER};

    axi_burst_addr_gen #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .SPAN(SPAN)) u_wgen (
        .i_addr(r_waddr), .i_size(r_wsize), .i_burst(r_wburst),
        .o_next_addr(w_wnext_addr), .o_next_in_range(w_wnext_in_range)
    );

    axi_burst_addr_gen #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .SPAN(SPAN)) u_rgen (
        .i_addr(r_raddr), .i_size(r_rsize), .i_burst(r_rburst),
        .o_next_addr(w_rnext_addr), .o_next_in_range(w_rnext_in_range)
    );

    // Handshake readies stay low until the first clock after reset release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_en <= 1'b0;
        else          r_en <= 1'b1;
    end

    assign S_AWREADY = r_en && (r_wstate == W_IDLE);
    assign S_WREADY  = (r_wstate == W_DATA);
    assign S_BVALID  = (r_wstate == W_RESP);
    assign S_BID     = r_wid;
    assign S_BRESP   = (S_BVALID && (r_werr || r_wlen_err)) ? RESP_SLVERR : RESP_OKAY;
    assign S_BUSER   = '0;
    assign w_aw_hs   = S_AWVALID && S_AWREADY;
    assign w_w_hs    = S_WVALID && S_WREADY;
    assign w_mem_we  = w_w_hs && !r_werr && (r_wbeat <= {1'b0, r_wlen});

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate   <= W_IDLE;
            r_wid      <= '0;
            r_waddr    <= '0;
            r_wlen     <= '0;
            r_wsize    <= '0;
            r_wburst   <= '0;
            r_werr     <= 1'b0;
            r_wlen_err <= 1'b0;
            r_wbeat    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_aw_hs) begin
                    r_wid      <= S_AWID;
                    r_waddr    <= S_AWADDR;
                    r_wlen     <= S_AWLEN;
                    r_wsize    <= S_AWSIZE;
                    r_wburst   <= S_AWBURST;
                    r_werr     <= req_err(S_AWADDR, S_AWBURST, S_AWSIZE);
                    r_wlen_err <= 1'b0;
                    r_wbeat    <= '0;
                    r_wstate   <= W_DATA;
                end
                W_DATA: if (w_w_hs) begin
                    if (r_wbeat != '1) r_wbeat <= r_wbeat + 1'b1;
                    if (S_WLAST) begin
                        if (r_wbeat != {1'b0, r_wlen}) r_wlen_err <= 1'b1;
                        r_wstate <= W_RESP;
                    end else begin
                        // Range is re-checked only when another beat follows.
                        r_waddr <= w_wnext_addr;
                        if (!w_wnext_in_range) r_werr <= 1'b1;
                        if (r_wbeat >= {1'b0, r_wlen}) r_wlen_err <= 1'b1;
                    end
                end
                W_RESP: if (S_BREADY) r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_WSTRB[b]) r_mem[mem_idx(r_waddr)][b*8 +: 8] <= S_WDATA[b*8 +: 8];
            end
        end
    end

    assign S_ARREADY = r_en && (r_rstate == R_IDLE);
    assign S_RVALID  = (r_rstate == R_DATA);
    assign S_RID     = r_rid;
    assign S_RDATA   = r_rdata;
    assign S_RRESP   = r_rresp;
    assign S_RLAST   = r_rlast;
    assign S_RUSER   = '0;
    assign w_ar_hs   = S_ARVALID && S_ARREADY;
    assign w_r_hs    = S_RVALID && S_RREADY;

    // Selects which beat (address, error, last) gets launched into the R registers.
    always_comb begin
        w_r_load    = 1'b0;
        w_r_ld_addr = r_raddr;
        w_r_ld_err  = r_rerr;
        w_r_ld_last = (r_rlen == '0);
        case (r_rstate)
            R_IDLE: begin
                w_r_load    = w_ar_hs && (RD_LATENCY == 1);
                w_r_ld_addr = S_ARADDR;
                w_r_ld_err  = req_err(S_ARADDR, S_ARBURST, S_ARSIZE);
                w_r_ld_last = (S_ARLEN == '0);
            end
            R_WAIT: w_r_load = (r_rcnt <= 4'd1);
            R_DATA: begin
                w_r_load    = w_r_hs && !r_rlast;
                w_r_ld_addr = w_rnext_addr;
                w_r_ld_err  = r_rerr || !w_rnext_in_range;
                w_r_ld_last = ((r_rbeat + 1'b1) == {1'b0, r_rlen});
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rerr   <= 1'b0;
            r_rbeat  <= '0;
            r_rcnt   <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_rlast  <= 1'b0;
        end else begin
            if (w_r_load) begin
                r_rdata <= w_r_ld_err ? '0 : r_mem[mem_idx(w_r_ld_addr)];
                r_rresp <= w_r_ld_err ? RESP_SLVERR : RESP_OKAY;
                r_rlast <= w_r_ld_last;
            end
            case (r_rstate)
                R_IDLE: if (w_ar_hs) begin
                    r_rid    <= S_ARID;
                    r_raddr  <= S_ARADDR;
                    r_rlen   <= S_ARLEN;
                    r_rsize  <= S_ARSIZE;
                    r_rburst <= S_ARBURST;
                    r_rerr   <= w_r_ld_err;
                    r_rbeat  <= '0;
                    r_rcnt   <= LAT_LOAD;
                    r_rstate <= (RD_LATENCY == 1) ? R_DATA : R_WAIT;
                end
                R_WAIT: begin
                    if (r_rcnt <= 4'd1) r_rstate <= R_DATA;
                    else                r_rcnt   <= r_rcnt - 4'd1;
                end
                R_DATA: if (w_r_hs) begin
                    if (r_rlast) begin
                        r_rstate <= R_IDLE;
                    end else begin
                        r_raddr <= w_rnext_addr;
                        r_rerr  <= w_r_ld_err;
                        r_rbeat <= r_rbeat + 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Directed bench for the AXI memory responder: expected B and R responses
// are queued as stimulus is issued and compared as the slave produces them.
module tb_axi_slave_mem_responder;

    localparam int LAT = 2;
    localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2;
    localparam logic [1:0] OKAY = 2'b00, SLV = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  S_AWID = '0, S_ARID = '0;
    logic [31:0] S_AWADDR = '0, S_ARADDR = '0;
    logic [7:0]  S_AWLEN = '0, S_ARLEN = '0;
    logic [2:0]  S_AWSIZE = 3'd2, S_ARSIZE = 3'd2;
    logic [1:0]  S_AWBURST = INCR, S_ARBURST = INCR;
    logic        S_AWVALID = 1'b0, S_ARVALID = 1'b0;
    logic [31:0] S_WDATA = '0;
    logic [3:0]  S_WSTRB = '0;
    logic        S_WLAST = 1'b0, S_WVALID = 1'b0;
    logic        S_BREADY = 1'b0, S_RREADY = 1'b1;
    logic        S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, S_RLAST;
    logic [3:0]  S_BID, S_RID;
    logic [1:0]  S_BRESP, S_RRESP;
    logic [0:0]  S_BUSER, S_RUSER;
    logic [31:0] S_RDATA;

    always #5 ACLK = ~ACLK;

    axi_slave_mem_responder #(
        .ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(8), .USER_W(1),
        .MEM_WORDS(1024), .BASE_ADDR(32'h0), .RD_LATENCY(LAT)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
        .S_AWBURST(S_AWBURST), .S_AWLOCK(1'b0), .S_AWCACHE(4'd0), .S_AWPROT(3'd0),
        .S_AWQOS(4'd0), .S_AWREGION(4'd0), .S_AWUSER(1'b0),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WUSER(1'b0),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BUSER(S_BUSER),
        .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
        .S_ARBURST(S_ARBURST), .S_ARLOCK(1'b0), .S_ARCACHE(4'd0), .S_ARPROT(3'd0),
        .S_ARQOS(4'd0), .S_ARREGION(4'd0), .S_ARUSER(1'b0),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .S_RUSER(S_RUSER), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
    );

    typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last;} rexp_t;
    typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [31:0] wd[4];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input logic last);
        rexp_t e;
        e.data = data; e.resp = resp; e.last = last;
        rq.push_back(e);
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input logic [3:0] strb, input int nbeats,
                      input logic [1:0] exp_resp, input int bstall);
        int n;
        bexp_t e;
        e.id = id; e.resp = exp_resp;
        bq.push_back(e);
        S_AWID = id; S_AWADDR = addr; S_AWLEN = len; S_AWSIZE = 3'd2; S_AWBURST = burst;
        S_AWVALID = 1'b1;
        n = 0;
        while (!S_AWREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("aw_accept", 64'(n < 50), 64'd1);
        @(negedge ACLK);
        S_AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            S_WDATA = wd[i]; S_WSTRB = strb; S_WLAST = (i == nbeats - 1); S_WVALID = 1'b1;
            n = 0;
            while (!S_WREADY && n < 50) begin @(negedge ACLK); n++; end
            chk("w_accept", 64'(n < 50), 64'd1);
            @(negedge ACLK);
        end
        S_WVALID = 1'b0; S_WLAST = 1'b0;
        n = 0;
        while (!S_BVALID && n < 50) begin @(negedge ACLK); n++; end
        chk("b_valid", 64'(n < 50), 64'd1);
        e = bq.pop_front();
        repeat (bstall) begin
            chk("b_hold_valid", 64'(S_BVALID), 64'd1);
            chk("b_hold_id", 64'(S_BID), 64'(e.id));
            chk("b_hold_resp", 64'(S_BRESP), 64'(e.resp));
            chk("aw_blocked", 64'(S_AWREADY), 64'd0);
            @(negedge ACLK);
        end
        chk("bid", 64'(S_BID), 64'(e.id));
        chk("bresp", 64'(S_BRESP), 64'(e.resp));
        S_BREADY = 1'b1;
        @(negedge ACLK);
        S_BREADY = 1'b0;
        chk("b_done", 64'(S_BVALID), 64'd0);
        chk("aw_ready_again", 64'(S_AWREADY), 64'd1);
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input int stall_beat, input int stop_beat);
        int n, lat;
        rexp_t e;
        S_ARID = id; S_ARADDR = addr; S_ARLEN = len; S_ARSIZE = 3'd2; S_ARBURST = burst;
        S_ARVALID = 1'b1;
        n = 0;
        while (!S_ARREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("ar_accept", 64'(n < 50), 64'd1);
        lat = 0;
        do begin
            @(negedge ACLK);
            if (lat == 0) S_ARVALID = 1'b0;
            lat++;
        end while (!S_RVALID && lat < 50);
        chk("r_latency", 64'(lat), 64'(LAT));
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!S_RVALID && n < 50) begin @(negedge ACLK); n++; end
            chk("r_valid", 64'(n < 50), 64'd1);
            if (b == stop_beat) begin
                S_RREADY = 1'b0;
                return;
            end
            e = rq.pop_front();
            if (b == stall_beat) begin
                S_RREADY = 1'b0;
                repeat (5) begin
                    @(negedge ACLK);
                    chk("r_hold_valid", 64'(S_RVALID), 64'd1);
                    chk("r_hold_data", 64'(S_RDATA), 64'(e.data));
                    chk("r_hold_id", 64'(S_RID), 64'(id));
                    chk("r_hold_last", 64'(S_RLAST), 64'(e.last));
                end
                S_RREADY = 1'b1;
            end
            chk("rdata", 64'(S_RDATA), 64'(e.data));
            chk("rresp", 64'(S_RRESP), 64'(e.resp));
            chk("rlast", 64'(S_RLAST), 64'(e.last));
            chk("rid", 64'(S_RID), 64'(id));
            @(negedge ACLK);
        end
        chk("r_idle", 64'(S_RVALID), 64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        repeat (3) @(negedge ACLK);
        chk("rst_awready", 64'(S_AWREADY), 64'd0);
        chk("rst_wready", 64'(S_WREADY), 64'd0);
        chk("rst_bvalid", 64'(S_BVALID), 64'd0);
        chk("rst_arready", 64'(S_ARREADY), 64'd0);
        chk("rst_rvalid", 64'(S_RVALID), 64'd0);
        chk("rst_rdata", 64'(S_RDATA), 64'd0);
        chk("rst_rlast_rresp", 64'({S_RLAST, S_RRESP, S_BRESP}), 64'd0);
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("awready_after_rst", 64'(S_AWREADY), 64'd1);
        chk("arready_after_rst", 64'(S_ARREADY), 64'd1);
        chk("wready_before_aw", 64'(S_WREADY), 64'd0);

        wd[0] = 32'h5555_AAAA;
        wr(4'h1, 32'h0, 8'd0, INCR, 4'hF, 1, OKAY, 0);

        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        wr(4'h3, 32'h10, 8'd3, INCR, 4'hF, 4, OKAY, 3);
        push_r(32'hA0, OKAY, 1'b0); push_r(32'hA1, OKAY, 1'b0);
        push_r(32'hA2, OKAY, 1'b0); push_r(32'hA3, OKAY, 1'b1);
        rd(4'h5, 32'h10, 8'd3, INCR, 2, -1);

        push_r(32'hA1, OKAY, 1'b0); push_r(32'hA1, OKAY, 1'b1);
        rd(4'hC, 32'h14, 8'd1, FIXED, -1, -1);

        wd[0] = 32'h1234_5678;
        wr(4'h4, 32'h20, 8'd0, INCR, 4'hF, 1, OKAY, 0);
        wd[0] = 32'hFFFF_FFFF;
        wr(4'h4, 32'h20, 8'd0, INCR, 4'h3, 1, OKAY, 0);
        push_r(32'h1234_FFFF, OKAY, 1'b1);
        rd(4'h6, 32'h20, 8'd0, INCR, -1, -1);

        wd[0] = 32'hDEAD_BEEF;
        wr(4'h7, 32'h1000, 8'd0, INCR, 4'hF, 1, SLV, 0);
        push_r(32'h5555_AAAA, OKAY, 1'b1);
        rd(4'h7, 32'h0, 8'd0, INCR, -1, -1);

        push_r(32'h0, SLV, 1'b0); push_r(32'h0, SLV, 1'b1);
        rd(4'h8, 32'h10, 8'd1, WRAP, -1, -1);

        wd[0] = 32'h11; wd[1] = 32'h22;
        wr(4'h2, 32'hFFC, 8'd1, INCR, 4'hF, 2, SLV, 0);
        push_r(32'h11, OKAY, 1'b0); push_r(32'h0, SLV, 1'b1);
        rd(4'h2, 32'hFFC, 8'd1, INCR, -1, -1);

        wd[0] = 32'hB0; wd[1] = 32'hB1;
        wr(4'hA, 32'h30, 8'd3, INCR, 4'hF, 2, SLV, 3);

        push_r(32'hA0, OKAY, 1'b0);
        rd(4'h9, 32'h10, 8'd3, INCR, -1, 1);
        #1 ARESETn = 1'b0;
        #1;
        chk("midburst_rst_rvalid", 64'(S_RVALID), 64'd0);
        chk("midburst_rst_arready", 64'(S_ARREADY), 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        S_RREADY = 1'b1;
        rq.delete();
        repeat (2) @(negedge ACLK);
        chk("arready_after_midrst", 64'(S_ARREADY), 64'd1);
        push_r(32'hA0, OKAY, 1'b1);
        rd(4'hE, 32'h10, 8'd0, INCR, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
